ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Parametrised successor to the fixed four-key PS/2 code-to-signal path.
- Consumes the byte stream from KeyboardPS2_Controller (received_data / received_data_en) and tracks make/break, E0 extended prefixes and the E1 Pause sequence.
- Keeps per-slot held state for NUM_KEYS programmable keys and emits single-cycle press and release pulses for game/benchmark FSMs.
- Instantiated between KeyboardPS2_Controller and the benchmark control logic; replaces the hard-wired space/enter/1/2 decode.

Parameters:
- NUM_KEYS, 4, number of tracked key slots (1..16).
- KEY_CODES, {8'h1E,8'h16,8'h5A,8'h29}, flattened 8*NUM_KEYS scan codes; slot i = bits [8i+7:8i]. Default slot0=space, slot1=enter, slot2='1', slot3='2'.
- KEY_EXT, 4'b0000, NUM_KEYS-bit mask; bit i=1 means slot i requires the E0 prefix.
- TIMEOUT_CYCLES, 50000, prefix timeout in clocks (1 ms at 50 MHz); used only with SCANCODE_TIMEOUT_EN.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- resetn  in  1  synchronous, active-low reset (top level drives KEY[0]).
- rx_data  in  8  byte from the PS/2 controller.
- rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle.
- key_held  out  NUM_KEYS  level; 1 while the slot's key is down.
- key_press  out  NUM_KEYS  one-cycle pulse on a slot's up->down transition.
- key_release  out  NUM_KEYS  one-cycle pulse on a slot's down->up transition.
- code_valid  out  1  one-cycle pulse when any complete make/break code is decoded.
- last_code  out  8  final byte of the last complete code.
- last_ext  out  1  last complete code carried the E0 prefix.
- last_break  out  1  last complete code was a break (F0).

Behaviour:
- Reset (resetn=0 at a clock edge):
  - All outputs go to 0.
  - FSM goes to IDLE; skip counter and timeout counter clear.
  - Takes precedence over a coincident rx_valid.
- Everything is registered. rx_valid at edge t produces updated outputs after edge t+1 (1-cycle latency). Pulses are high for exactly one cycle.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (Pause).
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> SKIP, with skip count = 7.
    - AA, FA, FC, FE, EE, 00, FF are ignored and stay in IDLE.
    - Any other byte is a make code with ext=0.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 stays in EXT (ignored).
    - 12 or 59 (fake shifts) are discarded; return to IDLE with no code_valid.
    - Any other byte is a make code with ext=1; -> IDLE.
  - BRK:
    - F0 or E0 is a protocol error; -> IDLE with no output.
    - Any other byte is a break code with ext=0; -> IDLE.
  - EXT_BRK:
    - 12 or 59 are discarded; -> IDLE.
    - F0 or E0 are errors; -> IDLE.
    - Any other byte is a break code with ext=1; -> IDLE.
  - SKIP: each rx_valid decrements the count. The next cycle after the count reaches 0, -> IDLE. Pause generates no output.
- Complete code handling:
  - code_valid=1; last_code, last_ext and last_break are updated.
  - Slot i matches when the code equals KEY_CODES[i] and ext equals KEY_EXT[i].
  - All matching slots update; duplicate slots are legal and act identically.
- Make on slot i:
  - If key_held[i]=0: set key_held[i] and pulse key_press[i].
  - If already held (typematic repeat): no pulse and no change.
- Break on slot i:
  - If key_held[i]=1: clear key_held[i] and pulse key_release[i].
  - If not held: no pulse.
- Distinct slots may press and release in the same cycle only through duplicates. Otherwise one code per rx_valid.
- rx_valid while in the SKIP final state follows the FSM rule for that state only; there is no byte buffering, because rx_valid spacing is at least 10 PS/2 bits.

Optional Feature:
- Macro: SCANCODE_TIMEOUT_EN.
- Defined:
  - A counter runs while in EXT, BRK, EXT_BRK or SKIP and is cleared on each rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the FSM returns to IDLE with no output. This recovers from a dropped byte.
  - If rx_valid arrives on the expiry cycle, the byte wins.
- Not defined:
  - No counter is built.
  - Prefix states persist until the next byte arrives.

Test Plan:
- Reset: resetn=0 for 2 cycles with rx_valid=1, rx_data=29 -> all outputs 0; after release, FSM is in IDLE.
- Basic make/break: send 29, then F0 29 -> key_press[0] pulses 1 cycle at t+1 and key_held[0]=1. On the break, key_release[0] pulses, key_held[0]=0, and last_break=1.
- Typematic repeat: send 5A, 5A, 5A -> a single key_press[1] pulse; key_held[1] stays 1; code_valid pulses 3 times.
- Extended keys: with KEY_EXT bit0=1 and KEY_CODES slot0=75, send 75 -> no slot change. Send E0 75 -> key_press[0]. Send E0 12 E0 75 -> the fake shift is discarded and slot0 is still held. Send E0 F0 75 -> key_release[0].
- Pause and noise: send AA, FA, then E1 14 77 E1 F0 14 F0 77, then 16 -> only the 16 produces output (key_press[2], code_valid=1 once).
- Timeout (SCANCODE_TIMEOUT_EN, TIMEOUT_CYCLES=100): send F0, idle 100 cycles, send 1E -> key_press[3] pulses (treated as a make). Without the macro, the same stimulus gives no press because F0 1E is a break.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: tracks make/break, E0 prefixes and the E1 Pause sequence,
// and keeps held state plus press/release pulses for NUM_KEYS slots. Optional: SCANCODE_TIMEOUT_EN.
module ps2_scancode_decoder #(
  parameter int unsigned             NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0]   KEY_CODES      = {8'h1E, 8'h16, 8'h5A, 8'h29},
  parameter logic [NUM_KEYS-1:0]     KEY_EXT        = 4'b0000,
  parameter int unsigned             TIMEOUT_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                code_valid,
  output logic [7:0]          last_code,
  output logic                last_ext,
  output logic                last_break
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t              state, state_n;
  logic [2:0]          skip_cnt, skip_n;
  logic [7:0]          rx_q;
  logic                rx_v_q;
  logic                code_hit, code_ext, code_brk;
  logic [NUM_KEYS-1:0] slot_hit, slot_make, slot_brk;
  logic                tmo_expired;

  // Input byte is registered first; decode acts on it one edge later.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      rx_q   <= '0;
      rx_v_q <= 1'b0;
    end else begin
      rx_q   <= rx_data;
      rx_v_q <= rx_valid;
    end
  end

`ifdef SCANCODE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;

  assign tmo_expired = (state != IDLE) && !rx_v_q && (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!resetn)
      tmo <= '0;
    else if (state == IDLE || rx_v_q || tmo_expired)
      tmo <= '0;
    else
      tmo <= tmo + TW'(1);
  end
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end

  always_comb begin
    state_n  = state;
    skip_n   = skip_cnt;
    code_hit = 1'b0;
    code_ext = 1'b0;
    code_brk = 1'b0;
    if (tmo_expired) begin
      state_n = IDLE;
      skip_n  = '0;
    end else begin
      case (state)
        IDLE: if (rx_v_q) begin
          case (rx_q)
            8'hE0: state_n = EXT;
            8'hF0: state_n = BRK;
            8'hE1: begin
              state_n = SKIP;
              skip_n  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFC, 8'hFE, 8'hEE, 8'h00, 8'hFF: state_n = IDLE;
            default: code_hit = 1'b1;
          endcase
        end
        EXT: if (rx_v_q) begin
          case (rx_q)
            8'hE0: state_n = EXT;
            8'hF0: state_n = EXT_BRK;
            8'h12, 8'h59: state_n = IDLE;
            default: begin
              state_n  = IDLE;
              code_hit = 1'b1;
              code_ext = 1'b1;
            end
          endcase
        end
        BRK: if (rx_v_q) begin
          state_n = IDLE;
          if (rx_q != 8'hF0 && rx_q != 8'hE0) begin
            code_hit = 1'b1;
            code_brk = 1'b1;
          end
        end
        EXT_BRK: if (rx_v_q) begin
          state_n = IDLE;
          case (rx_q)
            8'h12, 8'h59, 8'hF0, 8'hE0: code_hit = 1'b0;
            default: begin
              code_hit = 1'b1;
              code_ext = 1'b1;
              code_brk = 1'b1;
            end
          endcase
        end
        SKIP: begin
          // Count reached zero: leave on the following cycle, dropping any byte then.
          if (skip_cnt == 3'd0)
            state_n = IDLE;
          else if (rx_v_q)
            skip_n = skip_cnt - 3'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    slot_hit = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++)
      slot_hit[i] = code_hit && (rx_q == KEY_CODES[8*i +: 8]) && (code_ext == KEY_EXT[i]);
    slot_make = slot_hit & {NUM_KEYS{~code_brk}};
    slot_brk  = slot_hit & {NUM_KEYS{code_brk}};
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      code_valid  <= 1'b0;
      last_code   <= '0;
      last_ext    <= 1'b0;
      last_break  <= 1'b0;
    end else begin
      key_held    <= (key_held | slot_make) & ~slot_brk;
      key_press   <= slot_make & ~key_held;
      key_release <= slot_brk & key_held;
      code_valid  <= code_hit;
      if (code_hit) begin
        last_code  <= rx_q;
        last_ext   <= code_ext;
        last_break <= code_brk;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder: a default-slot instance and an
// instance with slot0 mapped to extended code E0 75.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic [3:0] held, press, release_p;
  logic       cv, lext, lbrk;
  logic [7:0] lcode;
  logic [3:0] x_held, x_press, x_release;
  logic       x_cv, x_lext, x_lbrk;
  logic [7:0] x_lcode;

  int n_checks = 0;
  int n_fail   = 0;
  int cv_cnt   = 0;
  logic [3:0] press_acc = '0;

  always #10 clk = ~clk;

  ps2_scancode_decoder #(.NUM_KEYS(4), .TIMEOUT_CYCLES(100)) dut (
    .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_held(held), .key_press(press), .key_release(release_p),
    .code_valid(cv), .last_code(lcode), .last_ext(lext), .last_break(lbrk));

  ps2_scancode_decoder #(
    .NUM_KEYS(4),
    .KEY_CODES({8'h1E, 8'h16, 8'h5A, 8'h75}),
    .KEY_EXT(4'b0001),
    .TIMEOUT_CYCLES(100)
  ) dut_x (
    .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .key_held(x_held), .key_press(x_press), .key_release(x_release),
    .code_valid(x_cv), .last_code(x_lcode), .last_ext(x_lext), .last_break(x_lbrk));

  // Pulse monitors for the default instance.
  always @(negedge clk) begin
    if (cv) cv_cnt = cv_cnt + 1;
    press_acc = press_acc | press;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte; returns #1 after the edge where its decode becomes visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h29;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held",  held, 0);
    check("rst_press", press, 0);
    check("rst_cv",    cv, 0);
    check("rst_code",  lcode, 0);
    check("rst_brk",   {lext, lbrk, release_p}, 0);
    @(negedge clk);
    resetn   = 1'b1;
    rx_valid = 1'b0;
    idle(3);
    check("post_rst_cv",   cv_cnt, 0);
    check("post_rst_held", held, 0);

    // Basic make with latency check
    @(negedge clk);
    rx_data  = 8'h29;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    check("make_lat", press, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    check("make_press", press, 4'b0001);
    check("make_held",  held, 4'b0001);
    check("make_cv",    cv, 1);
    check("make_code",  lcode, 8'h29);
    idle(1);
    check("press_1cyc", press, 0);
    check("cv_1cyc",    cv, 0);
    send(8'hF0);
    check("prefix_no_cv", cv, 0);
    send(8'h29);
    check("brk_release", release_p, 4'b0001);
    check("brk_held",    held, 0);
    check("brk_flag",    lbrk, 1);
    idle(1);
    check("release_1cyc", release_p, 0);

    // Typematic repeat
    cv_cnt = 0; press_acc = '0;
    send(8'h5A); send(8'h5A); send(8'h5A);
    idle(1);
    check("rep_cv_count", cv_cnt, 3);
    check("rep_press",    press_acc, 4'b0010);
    check("rep_held",     held, 4'b0010);
    send(8'hF0); send(8'h5A);
    check("rep_release",  release_p, 4'b0010);

    // Protocol error F0 F0 then a make
    send(8'hF0); send(8'hF0); send(8'h29);
    check("err_make", {press, lbrk}, {4'b0001, 1'b0});
    send(8'hF0); send(8'h29);
    check("err_clean", held, 0);

    // Extended slot on dut_x
    send(8'h75);
    check("x_plain_press", x_press, 0);
    check("x_plain_cv",    {x_cv, x_lext}, 2'b10);
    send(8'hE0); send(8'h75);
    check("x_ext_press", x_press, 4'b0001);
    check("x_ext_flag",  x_lext, 1);
    send(8'hE0); send(8'h12);
    check("x_fake_cv", x_cv, 0);
    send(8'hE0); send(8'h75);
    check("x_rep_press", x_press, 0);
    check("x_rep_held",  x_held, 4'b0001);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("x_release", x_release, 4'b0001);
    check("x_rel_flags", {x_held, x_lext, x_lbrk}, {4'b0000, 1'b1, 1'b1});

    // Noise and Pause
    idle(2);
    cv_cnt = 0; press_acc = '0;
    send(8'hAA); send(8'hFA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("pause_cv", cv_cnt, 0);
    send(8'h16);
    idle(1);
    check("pause_cv_16",  cv_cnt, 1);
    check("pause_press",  press_acc, 4'b0100);
    check("pause_code",   lcode, 8'h16);
    send(8'hF0); send(8'h16);
    check("rel_16", release_p, 4'b0100);
    send(8'hF0); send(8'h29);
    check("brk_unheld", {release_p, cv, lbrk}, {4'b0000, 1'b1, 1'b1});

    // Prefix timeout
    send(8'hF0);
    idle(100);
    send(8'h1E);
`ifdef SCANCODE_TIMEOUT_EN
    check("tmo_press", press, 4'b1000);
    check("tmo_flags", {held, lbrk}, {4'b1000, 1'b0});
`else
    check("tmo_press", press, 0);
    check("tmo_flags", {held, release_p, cv, lbrk}, {4'b0000, 4'b0000, 1'b1, 1'b1});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
